// File: rtl/fifo_sdp_ctrl.sv
// First-word-fall-through FIFO controller for an external simple dual-port RAM with registered read.
// Optional macro FIFO_LEVEL_EN adds a registered 'level' output (RAM words plus output register).
module fifo_sdp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_wenable,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_renable,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
    logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  pop;

    // count tracks RAM occupancy only; the RAM output register is the FIFO head
    always_comb begin
        in_ready    = ~reset & (count_reg != FULL_COUNT);
        ram_wenable = in_valid & in_ready;
        pop         = out_valid_reg & out_ready;
        ram_renable = ~reset & (count_reg != '0) & (~out_valid_reg | out_ready);

        wptr_next  = wptr_reg + {{(ADDR_WIDTH-1){1'b0}}, ram_wenable};
        rptr_next  = rptr_reg + {{(ADDR_WIDTH-1){1'b0}}, ram_renable};
        count_next = count_reg + {{ADDR_WIDTH{1'b0}}, ram_wenable}
                               - {{ADDR_WIDTH{1'b0}}, ram_renable};

        out_valid_next = out_valid_reg;
        if (ram_renable) begin
            out_valid_next = 1'b1;
        end else if (pop) begin
            out_valid_next = 1'b0;
        end
    end

    assign ram_waddr = wptr_reg;
    assign ram_wdata = in_data;
    assign ram_raddr = rptr_reg;
    assign out_data  = ram_rdata;
    assign out_valid = out_valid_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            out_valid_reg <= out_valid_next;
        end
    end

`ifdef FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] level_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_reg <= '0;
        end else begin
            level_reg <= count_next + {{ADDR_WIDTH{1'b0}}, out_valid_next};
        end
    end

    assign level = level_reg;
`endif

endmodule
